// File: rtl/router_pkg.sv
// Shared types and default widths for the GLB<->PE routers.
package router_pkg;

    localparam int ROUTER_DATA_BITWIDTH     = 16;
    localparam int ROUTER_ADDR_BITWIDTH_GLB = 10;

    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, DONE} psum_state_t;

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO buffering psums between the PE array and the GLB write port.
module psum_fifo #(
    parameter int DATA_BITWIDTH = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_BITWIDTH-1:0] din,
    output logic [DATA_BITWIDTH-1:0] dout,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_BITWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]           wr_ptr;
    logic [PTR_W:0]           rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/router_psum.sv
// Psum write-back router: accepts psums from the PE array and commits them to the GLB psum region.
module router_psum
    import router_pkg::*;
#(
    parameter int DATA_BITWIDTH     = ROUTER_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH_GLB = ROUTER_ADDR_BITWIDTH_GLB,
    parameter int PSUM_COUNT        = 9,
    parameter int PSUM_WRITE_ADDR   = 500,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_psum_ctrl,
    input  logic [DATA_BITWIDTH-1:0]     psum_in,
    input  logic                         psum_valid,
    output logic                         psum_ready,
    output logic [DATA_BITWIDTH-1:0]     w_data_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0] w_addr_glb_psum,
    output logic                         write_en_glb_psum,
    output logic                         busy,
    output logic                         write_done
);

    localparam int                         CNT_W      = $clog2(PSUM_COUNT + 1);
    localparam logic [CNT_W-1:0]           COUNT_LAST = CNT_W'(PSUM_COUNT);
    localparam logic [ADDR_BITWIDTH_GLB-1:0] BASE_ADDR = ADDR_BITWIDTH_GLB'(PSUM_WRITE_ADDR);

    psum_state_t              state;
    psum_state_t              next_state;
    logic [CNT_W-1:0]         acc_cnt;
    logic [CNT_W-1:0]         wr_cnt;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_BITWIDTH-1:0] fifo_head;
    logic                     push;
    logic                     pop;

    psum_fifo #(
        .DATA_BITWIDTH(DATA_BITWIDTH),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (psum_in),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        psum_ready = 1'b0;
        busy       = 1'b1;
        write_done = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (write_psum_ctrl) next_state = ACTIVE;
            end
            ACTIVE: begin
                psum_ready = !fifo_full && (acc_cnt < COUNT_LAST);
                pop        = !fifo_empty;
                if (acc_cnt == COUNT_LAST) next_state = FLUSH;
            end
            FLUSH: begin
                pop = !fifo_empty;
                if (wr_cnt == COUNT_LAST) next_state = DONE;
            end
            DONE: begin
                write_done = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign push = psum_valid && psum_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else if (state == IDLE && write_psum_ctrl) begin
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            if (push) acc_cnt <= acc_cnt + CNT_W'(1);
            if (pop)  wr_cnt  <= wr_cnt + CNT_W'(1);
        end
    end

    // GLB write stage: the word popped at an edge is presented for exactly the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_en_glb_psum <= 1'b0;
            w_data_glb_psum   <= '0;
            w_addr_glb_psum   <= BASE_ADDR;
        end else begin
            write_en_glb_psum <= pop;
            if (pop) begin
                w_data_glb_psum <= fifo_head;
                w_addr_glb_psum <= BASE_ADDR + ADDR_BITWIDTH_GLB'(wr_cnt);
            end
        end
    end

endmodule

// File: tb/tb_router_psum.sv
// Directed bench for router_psum: default base address plus a second instance at a wrapping base.
module tb_router_psum;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_psum_ctrl;
    logic [15:0] psum_in;
    logic        psum_valid;

    logic        psum_ready, write_en, busy, write_done;
    logic [15:0] w_data;
    logic [9:0]  w_addr;
    logic        psum_ready_w, write_en_w, busy_w, write_done_w;
    logic [15:0] w_data_w;
    logic [9:0]  w_addr_w;

    always #5 clk = ~clk;

    router_psum #(.PSUM_WRITE_ADDR(500)) dut (
        .clk(clk), .reset(reset), .write_psum_ctrl(write_psum_ctrl),
        .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .w_data_glb_psum(w_data), .w_addr_glb_psum(w_addr),
        .write_en_glb_psum(write_en), .busy(busy), .write_done(write_done)
    );

    router_psum #(.PSUM_WRITE_ADDR(1020)) dut_wrap (
        .clk(clk), .reset(reset), .write_psum_ctrl(write_psum_ctrl),
        .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready_w),
        .w_data_glb_psum(w_data_w), .w_addr_glb_psum(w_addr_w),
        .write_en_glb_psum(write_en_w), .busy(busy_w), .write_done(write_done_w)
    );

    typedef struct {
        logic [15:0] din_a;
        logic [15:0] din_b;
        logic [9:0]  addr;
        logic [9:0]  addr_wrap;
    } vec_t;

    vec_t tbl [9];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] wd0 [$];
    logic [9:0]  wa0 [$];
    logic [15:0] wd1 [$];
    logic [9:0]  wa1 [$];
    int accepts, done_cnt, sync_mis;
    int first_acc_cyc, first_wr_cyc, last_wr_cyc, done_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (write_en) begin
            wd0.push_back(w_data);
            wa0.push_back(w_addr);
            wd1.push_back(w_data_w);
            wa1.push_back(w_addr_w);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (psum_valid && psum_ready) begin
            accepts++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (write_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (psum_ready_w !== psum_ready || write_en_w !== write_en ||
            busy_w !== busy || write_done_w !== write_done)
            sync_mis++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_log();
        wd0.delete(); wa0.delete(); wd1.delete(); wa1.delete();
        accepts = 0; done_cnt = 0; sync_mis = 0;
        first_acc_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1;
    endtask

    task automatic start_pass();
        write_psum_ctrl = 1'b1;
        @(posedge clk); #1;
        write_psum_ctrl = 1'b0;
    endtask

    // Offers words first..first+n-1; a word refused for 4 cycles is dropped.
    task automatic send(input int first, input int n, input bit use_b, input int gap);
        for (int i = 0; i < n; i++) begin
            int  idx;
            int  tries;
            bit  acc;
            idx   = first + i;
            psum_in = (idx < 9) ? (use_b ? tbl[idx].din_b : tbl[idx].din_a) : 16'hDE00 + 16'(idx);
            psum_valid = 1'b1;
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 4) begin
                @(negedge clk);
                acc = psum_ready;
                @(posedge clk); #1;
                tries++;
            end
            psum_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int exp_done);
        int n = 0;
        while (done_cnt < exp_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 32'(done_cnt >= exp_done), 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic verify_pass(input string tag, input bit use_b);
        chk({tag, "_writes"}, 32'(wa0.size()), 32'd9);
        chk({tag, "_accepts"}, 32'(accepts), 32'd9);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_after_last"}, 32'(done_cyc - last_wr_cyc), 32'd1);
        chk({tag, "_wrap_inst_sync"}, 32'(sync_mis), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        for (int i = 0; i < 9 && i < wa0.size(); i++) begin
            logic [15:0] exp_d;
            exp_d = use_b ? tbl[i].din_b : tbl[i].din_a;
            chk($sformatf("%s_data[%0d]", tag, i), 32'(wd0[i]), 32'(exp_d));
            chk($sformatf("%s_addr[%0d]", tag, i), 32'(wa0[i]), 32'(tbl[i].addr));
            chk($sformatf("%s_wrap_data[%0d]", tag, i), 32'(wd1[i]), 32'(exp_d));
            chk($sformatf("%s_wrap_addr[%0d]", tag, i), 32'(wa1[i]), 32'(tbl[i].addr_wrap));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(psum_ready), 32'd0);
        chk({tag, "_wen"}, 32'(write_en), 32'd0);
        chk({tag, "_wdata"}, 32'(w_data), 32'd0);
        chk({tag, "_waddr"}, 32'(w_addr), 32'd500);
        chk({tag, "_waddr_wrapinst"}, 32'(w_addr_w), 32'd1020);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(write_done), 32'd0);
    endtask

    initial begin
        tbl[0] = '{16'd1, 16'hFFFF, 10'd500, 10'd1020};
        tbl[1] = '{16'd2, 16'h8000, 10'd501, 10'd1021};
        tbl[2] = '{16'd3, 16'h7FFF, 10'd502, 10'd1022};
        tbl[3] = '{16'd4, 16'h0000, 10'd503, 10'd1023};
        tbl[4] = '{16'd5, 16'h1234, 10'd504, 10'd0};
        tbl[5] = '{16'd6, 16'hA5A5, 10'd505, 10'd1};
        tbl[6] = '{16'd7, 16'h5A5A, 10'd506, 10'd2};
        tbl[7] = '{16'd8, 16'h00FF, 10'd507, 10'd3};
        tbl[8] = '{16'd9, 16'hFF00, 10'd508, 10'd4};

        reset = 1'b0; write_psum_ctrl = 1'b0; psum_in = '0; psum_valid = 1'b0;
        clear_log();
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Continuous stream; valid held in IDLE first must be ignored.
        psum_valid = 1'b1; psum_in = 16'h7777;
        @(posedge clk); #1;
        psum_valid = 1'b0;
        clear_log();
        chk("idle_ignores_valid", 32'(busy), 32'd0);
        start_pass();
        @(negedge clk);
        chk("active_busy", 32'(busy), 32'd1);
        chk("active_ready", 32'(psum_ready), 32'd1);
        @(posedge clk); #1;
        send(0, 9, 1'b0, 0);
        wait_done(1);
        chk("stream_latency", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
        chk("stream_throughput", 32'(last_wr_cyc - first_wr_cyc), 32'd8);
        verify_pass("stream", 1'b0);

        // Gapped valid: one on, two off.
        clear_log();
        start_pass();
        send(0, 9, 1'b1, 2);
        wait_done(1);
        verify_pass("gapped", 1'b1);

        // Twelve offered words: only nine taken, and ready stays low once the pass is full.
        clear_log();
        start_pass();
        send(0, 12, 1'b1, 0);
        wait_done(1);
        verify_pass("excess", 1'b1);

        // Start pulse mid-pass must not restart counters.
        clear_log();
        start_pass();
        send(0, 4, 1'b0, 0);
        start_pass();
        send(4, 5, 1'b0, 0);
        wait_done(1);
        verify_pass("ignored_start", 1'b0);

        // Async reset held three cycles mid-pass, then a clean pass.
        clear_log();
        start_pass();
        send(0, 4, 1'b1, 0);
        psum_valid = 1'b1; psum_in = 16'hBEEF;
        reset = 1'b0;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk_reset_outputs("midreset");
        psum_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_log();
        start_pass();
        send(0, 9, 1'b0, 0);
        wait_done(1);
        verify_pass("after_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
